// File: rtl/sa_weight_load_stall.sv
// Weight-stationary SA_SIZE x SA_SIZE systolic GEMM array with row-shift weight
// loading and ready/valid flow control; the whole array stalls on backpressure.
module sa_weight_load_stall #(
   parameter int unsigned SA_SIZE         = 4,
   parameter int unsigned WEIGHT_SIZE     = 8,
   parameter int unsigned ACTIVATION_SIZE = 8,
   parameter int unsigned ACC_SIZE        = 16
) (
   input  logic                                          clk,
   input  logic                                          resetn,
   input  logic                                          w_valid,
   input  logic [SA_SIZE-1:0][WEIGHT_SIZE-1:0]           w_row,
   output logic                                          weights_loaded,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]       inputs,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [SA_SIZE-1:0][ACC_SIZE-1:0]              outputs
);

   localparam int unsigned FILL_MAX = 2 * SA_SIZE - 2;
   localparam int unsigned CNT_W    = $clog2(2 * SA_SIZE - 1);
   localparam int unsigned ROW_W    = $clog2(SA_SIZE);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [ROW_W-1:0]       row_cnt_q, row_cnt_d;
   logic [CNT_W-1:0]       fill_cnt_q, fill_cnt_d;

   logic [WEIGHT_SIZE-1:0]     w_q   [SA_SIZE][SA_SIZE];
   logic [ACTIVATION_SIZE-1:0] pin_q [SA_SIZE][SA_SIZE-1];
   logic [ACC_SIZE-1:0]        acc_q [SA_SIZE-1][SA_SIZE];

   logic [ACTIVATION_SIZE-1:0] pe_in  [SA_SIZE][SA_SIZE];
   logic [ACC_SIZE-1:0]        pe_acc [SA_SIZE][SA_SIZE];
   logic [ACC_SIZE-1:0]        pe_out [SA_SIZE][SA_SIZE];

   logic primed;
   logic advance;
   logic clear_pipe;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= EMPTY;
         row_cnt_q  <= '0;
         fill_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         row_cnt_q  <= row_cnt_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   // Next-state: a weight beat always wins over an activation advance
   always_comb begin
      state_d    = state_q;
      row_cnt_d  = row_cnt_q;
      fill_cnt_d = fill_cnt_q;
      if (advance && (fill_cnt_q != CNT_W'(FILL_MAX))) begin
         fill_cnt_d = fill_cnt_q + CNT_W'(1);
      end
      case (state_q)
         EMPTY, READY: begin
            if (w_valid) begin
               state_d    = LOADING;
               row_cnt_d  = ROW_W'(1);
               fill_cnt_d = '0;
            end
         end
         LOADING: begin
            if (w_valid) begin
               if (row_cnt_q == ROW_W'(SA_SIZE - 1)) begin
                  state_d   = READY;
                  row_cnt_d = '0;
               end else begin
                  row_cnt_d = row_cnt_q + ROW_W'(1);
               end
            end
         end
         default: begin
            state_d    = EMPTY;
            row_cnt_d  = '0;
            fill_cnt_d = '0;
         end
      endcase
   end

   // Handshake outputs
   always_comb begin
      primed         = (fill_cnt_q == CNT_W'(FILL_MAX));
      weights_loaded = (state_q == READY);
      in_ready       = weights_loaded & ~w_valid & (out_ready | ~primed);
      advance        = in_valid & in_ready;
      out_valid      = advance & primed;
      clear_pipe     = w_valid & (state_q != LOADING);
   end

   // PE grid: activations flow right, partial sums flow down
   for (genvar r = 0; r < SA_SIZE; r++) begin : g_row
      for (genvar c = 0; c < SA_SIZE; c++) begin : g_col
         if (c == 0) begin : g_in_edge
            assign pe_in[r][c] = inputs[r];
         end else begin : g_in_chain
            assign pe_in[r][c] = pin_q[r][c-1];
         end
         if (r == 0) begin : g_acc_edge
            assign pe_acc[r][c] = '0;
         end else begin : g_acc_chain
            assign pe_acc[r][c] = acc_q[r-1][c];
         end
         assign pe_out[r][c] = pe_acc[r][c]
                             + ACC_SIZE'(pe_in[r][c]) * ACC_SIZE'(w_q[r][c]);
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < SA_SIZE; c++) begin
         outputs[c] = pe_out[SA_SIZE-1][c];
      end
   end

   // Weight shift chain and pipeline registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned r = 0; r < SA_SIZE; r++) begin
            for (int unsigned c = 0; c < SA_SIZE; c++) begin
               w_q[r][c] <= '0;
            end
            for (int unsigned c = 0; c < SA_SIZE - 1; c++) begin
               pin_q[r][c] <= '0;
            end
         end
         for (int unsigned r = 0; r < SA_SIZE - 1; r++) begin
            for (int unsigned c = 0; c < SA_SIZE; c++) begin
               acc_q[r][c] <= '0;
            end
         end
      end else begin
         if (w_valid) begin
            for (int unsigned c = 0; c < SA_SIZE; c++) begin
               w_q[0][c] <= w_row[c];
            end
            for (int unsigned r = 1; r < SA_SIZE; r++) begin
               for (int unsigned c = 0; c < SA_SIZE; c++) begin
                  w_q[r][c] <= w_q[r-1][c];
               end
            end
         end
         if (clear_pipe) begin
            for (int unsigned r = 0; r < SA_SIZE; r++) begin
               for (int unsigned c = 0; c < SA_SIZE - 1; c++) begin
                  pin_q[r][c] <= '0;
               end
            end
            for (int unsigned r = 0; r < SA_SIZE - 1; r++) begin
               for (int unsigned c = 0; c < SA_SIZE; c++) begin
                  acc_q[r][c] <= '0;
               end
            end
         end else if (advance) begin
            for (int unsigned r = 0; r < SA_SIZE; r++) begin
               for (int unsigned c = 0; c < SA_SIZE - 1; c++) begin
                  pin_q[r][c] <= pe_in[r][c];
               end
            end
            for (int unsigned r = 0; r < SA_SIZE - 1; r++) begin
               for (int unsigned c = 0; c < SA_SIZE; c++) begin
                  acc_q[r][c] <= pe_out[r][c];
               end
            end
         end
      end
   end

endmodule
